// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared definitions for the ID-stage hazard scoreboard:
//                instruction class encodings, the zero register index and the
//                class-to-forwarding-latency helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_MUL  = 2'd2;
    localparam logic [1:0] CLS_RSVD = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Cycles a result of the given class needs before forwarding can supply it.
    // The reserved encoding behaves like an ALU op.
    function automatic logic [7:0] lat_of(input logic [1:0] cls,
                                          input int unsigned loadLat,
                                          input int unsigned mulLat);
        logic [7:0] lat;
        lat = 8'd0;
        case (cls)
            CLS_LOAD: lat = 8'(loadLat);
            CLS_MUL:  lat = 8'(mulLat);
            default:  lat = 8'd0;
        endcase
        return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_reg_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_reg_counter
//  Description : Per-register countdown of cycles until the in-flight result
//                is forwardable. Priority: clear > load > decrement.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_reg_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_loadVal,
    output logic [CNT_W-1:0] o_count,
    output logic             o_busy
);

    logic [CNT_W-1:0] r_count;

    // Countdown: a killed producer clears, a new producer reloads, else drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_busy  = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : ID-stage interlock. Tracks per architectural register the
//                cycles until an in-flight result is forwardable and stalls
//                issue when a source (or WAW destination) is not yet ready.
//                Optional macro HAZARD_STATS_EN enables the saturating
//                StallCount statistic; otherwise StallCount reads zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 4,
    parameter int CNT_W    = 3   // must hold max(LOAD_LAT, MUL_LAT)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ID_Valid,
    input  logic [4:0]  ID_RegRs,
    input  logic [4:0]  ID_RegRt,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        ID_RegWrite,
    input  logic [4:0]  ID_RegRd,
    input  logic [1:0]  ID_Class,
    input  logic        EX_Flush,
    output logic        Stall,
    output logic        IDEX_Bubble,
    output logic [31:0] StallCount
);

    logic [CNT_W-1:0] w_cnt [32];
    logic [31:0]      w_busy;
    logic [7:0]       w_rdLat;
    logic             w_rsHaz;
    logic             w_rtHaz;
    logic             w_wawHaz;
    logic             w_issue;
    logic             w_issueWrite;
    logic [4:0]       r_lastRd;
    logic             r_lastValid;

    // Register 0 is hard-wired and never has a pending producer.
    assign w_cnt[0]  = '0;
    assign w_busy[0] = 1'b0;

    assign w_rdLat  = lat_of(ID_Class, LOAD_LAT, MUL_LAT);
    assign w_rsHaz  = ID_UsesRs && (ID_RegRs != REG_ZERO) && w_busy[ID_RegRs];
    assign w_rtHaz  = ID_UsesRt && (ID_RegRt != REG_ZERO) && w_busy[ID_RegRt];
    // A new writer must not become forwardable before an older one to the same Rd.
    assign w_wawHaz = ID_RegWrite && (ID_RegRd != REG_ZERO) &&
                      ({{(8-CNT_W){1'b0}}, w_cnt[ID_RegRd]} > w_rdLat);

    assign Stall        = ID_Valid && (w_rsHaz || w_rtHaz || w_wawHaz);
    assign IDEX_Bubble  = Stall || EX_Flush;
    assign w_issue      = ID_Valid && !Stall && !EX_Flush;
    assign w_issueWrite = w_issue && ID_RegWrite && (ID_RegRd != REG_ZERO);

    generate
        for (genvar r = 1; r < 32; r++) begin : g_reg
            hazard_reg_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_clear   (EX_Flush && r_lastValid && (r_lastRd == 5'(r))),
                .i_load    (w_issueWrite && (ID_RegRd == 5'(r))),
                .i_loadVal (w_rdLat[CNT_W-1:0]),
                .o_count   (w_cnt[r]),
                .o_busy    (w_busy[r])
            );
        end
    endgenerate

    // Remember the previous cycle's issued writer so a flush can cancel it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastRd    <= REG_ZERO;
            r_lastValid <= 1'b0;
        end else begin
            r_lastRd    <= ID_RegRd;
            r_lastValid <= w_issueWrite;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stallCount;

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCount <= 32'd0;
        end else if (Stall && (r_stallCount != 32'hFFFF_FFFF)) begin
            r_stallCount <= r_stallCount + 32'd1;
        end
    end

    assign StallCount = r_stallCount;
`else
    assign StallCount = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard. Each cycle's
//                expected Stall/IDEX_Bubble is queued when the ID inputs are
//                driven and compared when the outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        ID_Valid;
    logic [4:0]  ID_RegRs;
    logic [4:0]  ID_RegRt;
    logic        ID_UsesRs;
    logic        ID_UsesRt;
    logic        ID_RegWrite;
    logic [4:0]  ID_RegRd;
    logic [1:0]  ID_Class;
    logic        EX_Flush;
    logic        Stall;
    logic        IDEX_Bubble;
    logic [31:0] StallCount;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uRs;
        logic       uRt;
        logic       rw;
        logic [4:0] rd;
        logic [1:0] cls;
        logic       flush;
        logic       eStall;
        logic       eBubble;
    } stim_t;

    typedef struct {
        logic stall;
        logic bubble;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nPass   = 0;

    hazard_scoreboard #(
        .LOAD_LAT (1),
        .MUL_LAT  (4),
        .CNT_W    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ID_Valid    (ID_Valid),
        .ID_RegRs    (ID_RegRs),
        .ID_RegRt    (ID_RegRt),
        .ID_UsesRs   (ID_UsesRs),
        .ID_UsesRt   (ID_UsesRt),
        .ID_RegWrite (ID_RegWrite),
        .ID_RegRd    (ID_RegRd),
        .ID_Class    (ID_Class),
        .EX_Flush    (EX_Flush),
        .Stall       (Stall),
        .IDEX_Bubble (IDEX_Bubble),
        .StallCount  (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uRs, input logic uRt, input logic rw,
                                 input logic [4:0] rd, input logic [1:0] cls, input logic flush,
                                 input logic eStall, input logic eBubble);
        stim_t s;
        s.valid = valid; s.rs = rs; s.rt = rt; s.uRs = uRs; s.uRt = uRt;
        s.rw = rw; s.rd = rd; s.cls = cls; s.flush = flush;
        s.eStall = eStall; s.eBubble = eBubble;
        return s;
    endfunction

    // Drive one ID cycle just after the edge and queue its expected outputs.
    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk); #1;
        ID_Valid = s.valid; ID_RegRs = s.rs; ID_RegRt = s.rt;
        ID_UsesRs = s.uRs; ID_UsesRt = s.uRt; ID_RegWrite = s.rw;
        ID_RegRd = s.rd; ID_Class = s.cls; EX_Flush = s.flush;
        e.stall = s.eStall; e.bubble = s.eBubble;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        ID_Valid = 0; ID_UsesRs = 0; ID_UsesRt = 0; ID_RegWrite = 0; EX_Flush = 0;
        ID_RegRs = 0; ID_RegRt = 0; ID_RegRd = 0; ID_Class = 0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(1, 0, 0, 0, 0, 1, 5, 2'd2, 0, 0, 0));  // MUL r5
        s.push_back(mk(1, 5, 0, 1, 0, 0, 0, 2'd0, 0, 1, 1));  // reader of r5 stalls
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            @(negedge clk);
            e = expQ.pop_front();
            nChecks++;
            if (Stall !== e.stall || IDEX_Bubble !== e.bubble)
                $display("FAIL reset_pre[%0d] Stall=%b Bubble=%b expected %b/%b", i, Stall, IDEX_Bubble, e.stall, e.bubble);
            else nPass++;
        end
        #1 rst_n = 1'b0;
        #1;
        nChecks++;
        if (Stall !== 1'b0 || IDEX_Bubble !== 1'b0)
            $display("FAIL reset_async Stall=%b Bubble=%b expected 0/0", Stall, IDEX_Bubble);
        else nPass++;
        @(negedge clk); #2 rst_n = 1'b1;
        s.delete();
        s.push_back(mk(1, 5, 5, 1, 1, 0, 0, 2'd0, 0, 0, 0));  // r5 discarded by reset
        s.push_back(mk(1, 5, 9, 1, 1, 1, 11, 2'd0, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            @(negedge clk);
            e = expQ.pop_front();
            nChecks++;
            if (Stall !== e.stall || IDEX_Bubble !== e.bubble)
                $display("FAIL reset_post[%0d] Stall=%b Bubble=%b expected %b/%b", i, Stall, IDEX_Bubble, e.stall, e.bubble);
            else nPass++;
        end
        nChecks++;
        if (StallCount !== 32'd0)
            $display("FAIL reset_stallcount StallCount=%0d expected 0", StallCount);
        else nPass++;
        idle(6);
    endtask

    task automatic test_load_use();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(1, 0, 0, 0, 0, 1, 8, 2'd1, 0, 0, 0));   // LOAD r8
        s.push_back(mk(1, 8, 3, 1, 1, 1, 12, 2'd0, 0, 1, 1));  // ADD r12 <- r8: stall
        s.push_back(mk(1, 8, 3, 1, 1, 1, 12, 2'd0, 0, 0, 0));  // issues
        s.push_back(mk(1, 12, 0, 1, 0, 0, 0, 2'd0, 0, 0, 0));  // ALU result forwardable
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            @(negedge clk);
            e = expQ.pop_front();
            nChecks++;
            if (Stall !== e.stall || IDEX_Bubble !== e.bubble)
                $display("FAIL load_use[%0d] Stall=%b Bubble=%b expected %b/%b", i, Stall, IDEX_Bubble, e.stall, e.bubble);
            else nPass++;
        end
        idle(6);
    endtask

    task automatic test_mul_use(output int stalls);
        stim_t s[$];
        exp_t  e;
        stalls = 0;
        s.push_back(mk(1, 0, 0, 0, 0, 1, 9, 2'd2, 0, 0, 0));   // MUL r9
        for (int k = 0; k < 4; k++)
            s.push_back(mk(1, 2, 9, 1, 1, 1, 15, 2'd0, 0, 1, 1));
        s.push_back(mk(1, 2, 9, 1, 1, 1, 15, 2'd0, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 9, 2'd2, 0, 0, 0));   // MUL r9 again
        s.push_back(mk(1, 1, 9, 1, 0, 0, 0, 2'd0, 0, 0, 0));   // Rt=9 not read
        s.push_back(mk(1, 9, 0, 1, 0, 0, 0, 2'd0, 0, 1, 1));   // Rs=9 read: stall
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            @(negedge clk);
            e = expQ.pop_front();
            if (e.stall && i < 6) stalls++;
            nChecks++;
            if (Stall !== e.stall || IDEX_Bubble !== e.bubble)
                $display("FAIL mul_use[%0d] Stall=%b Bubble=%b expected %b/%b", i, Stall, IDEX_Bubble, e.stall, e.bubble);
            else nPass++;
        end
        idle(6);
    endtask

    task automatic test_flush();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(1, 0, 0, 0, 0, 1, 10, 2'd1, 0, 0, 0));  // LOAD r10
        s.push_back(mk(1, 10, 0, 1, 0, 0, 0, 2'd0, 1, 1, 1));  // flush, dependent in ID
        s.push_back(mk(1, 10, 0, 1, 0, 0, 0, 2'd0, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 10, 2'd2, 0, 0, 0));  // MUL r10
        s.push_back(mk(1, 0, 0, 0, 0, 1, 13, 2'd2, 1, 0, 1));  // flush kills MUL r10, MUL r13 not issued
        s.push_back(mk(1, 10, 13, 1, 1, 0, 0, 2'd0, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            @(negedge clk);
            e = expQ.pop_front();
            nChecks++;
            if (Stall !== e.stall || IDEX_Bubble !== e.bubble)
                $display("FAIL flush[%0d] Stall=%b Bubble=%b expected %b/%b", i, Stall, IDEX_Bubble, e.stall, e.bubble);
            else nPass++;
        end
        idle(6);
    endtask

    task automatic test_waw_r0();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(1, 0, 0, 0, 0, 1, 11, 2'd2, 0, 0, 0));  // MUL r11
        for (int k = 0; k < 4; k++)
            s.push_back(mk(1, 0, 0, 0, 0, 1, 11, 2'd0, 0, 1, 1));  // ALU r11 waits
        s.push_back(mk(1, 0, 0, 0, 0, 1, 11, 2'd0, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 11, 2'd2, 0, 0, 0));  // MUL r11
        for (int k = 0; k < 3; k++)
            s.push_back(mk(1, 0, 0, 0, 0, 1, 11, 2'd1, 0, 1, 1));  // LOAD r11: cnt > 1
        s.push_back(mk(1, 0, 0, 0, 0, 1, 11, 2'd1, 0, 0, 0));  // cnt == 1: issue
        s.push_back(mk(1, 11, 0, 1, 0, 0, 0, 2'd0, 0, 1, 1));
        s.push_back(mk(1, 11, 0, 1, 0, 0, 0, 2'd0, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2'd1, 0, 0, 0));   // LOAD r0
        s.push_back(mk(1, 0, 0, 1, 1, 1, 0, 2'd2, 0, 0, 0));   // read r0, MUL r0
        s.push_back(mk(1, 0, 0, 1, 1, 1, 0, 2'd0, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            @(negedge clk);
            e = expQ.pop_front();
            nChecks++;
            if (Stall !== e.stall || IDEX_Bubble !== e.bubble)
                $display("FAIL waw_r0[%0d] Stall=%b Bubble=%b expected %b/%b", i, Stall, IDEX_Bubble, e.stall, e.bubble);
            else nPass++;
        end
        idle(6);
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        exp_t  e;
        for (int k = 1; k <= 4; k++)
            s.push_back(mk(1, 5'(k + 15), 5'(k + 20), 1, 1, 1, 5'(k), 2'd0, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 14, 2'd3, 0, 0, 0));  // reserved class: ALU
        s.push_back(mk(1, 14, 4, 1, 1, 1, 14, 2'd0, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            step(s[i]);
            @(negedge clk);
            e = expQ.pop_front();
            nChecks++;
            if (Stall !== e.stall || IDEX_Bubble !== e.bubble)
                $display("FAIL back_to_back[%0d] Stall=%b Bubble=%b expected %b/%b", i, Stall, IDEX_Bubble, e.stall, e.bubble);
            else nPass++;
        end
        idle(6);
    endtask

    task automatic test_stats();
        int stalls;
        logic [31:0] expCount;
        @(negedge clk); rst_n = 1'b0;
        #2 rst_n = 1'b1;
        test_mul_use(stalls);
`ifdef HAZARD_STATS_EN
        // test_mul_use ends with one extra stall cycle past the 4 counted
        expCount = 32'(stalls + 1);
`else
        expCount = 32'd0;
`endif
        nChecks++;
        if (StallCount !== expCount)
            $display("FAIL stats StallCount=%0d expected %0d", StallCount, expCount);
        else nPass++;
    endtask

    initial begin
        int dummy;
        rst_n = 1'b0;
        ID_Valid = 1; ID_RegRs = 5; ID_RegRt = 0; ID_UsesRs = 1; ID_UsesRt = 0;
        ID_RegWrite = 0; ID_RegRd = 0; ID_Class = 0; EX_Flush = 0;
        #2;
        nChecks++;
        if (Stall !== 1'b0 || IDEX_Bubble !== 1'b0 || StallCount !== 32'd0)
            $display("FAIL init Stall=%b Bubble=%b StallCount=%0d expected 0/0/0", Stall, IDEX_Bubble, StallCount);
        else nPass++;
        #10 rst_n = 1'b1;
        test_reset();
        test_load_use();
        test_mul_use(dummy);
        test_flush();
        test_waw_r0();
        test_back_to_back();
        test_stats();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
